// File: rtl/lab6_master_hs_tx.sv
// Switch-code transmitter: debounces a one-hot switch bank into a code and
// sends each new stable code to a slave over a 4-phase req/ack handshake.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | req low; waits for a stable code differing from last_sent
//   REQ      | req high; waits for synchronized ack or handshake timeout
//   WAIT_LOW | req low; waits for ack to fall, then commits last_sent
module lab6_master_hs_tx #(
    parameter int N_SW       = 8,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1024,
    localparam int W         = $clog2(N_SW) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw,
    input  logic            ack,
    output logic [W-1:0]    data_out,
    output logic            req,
    output logic            err
);

    localparam logic [W-1:0] INVALID = {1'b1, {(W-1){1'b0}}};
    localparam int SCW = $clog2(STABLE_CYC + 1);
    localparam int TOW = $clog2(TIMEOUT);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYC);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_LOW = 2'd2;

    logic [W-1:0]   code;
    logic [W-1:0]   idx;
    logic           onehot;
    logic           stable;

    logic [W-1:0]   code_q, code_d;
    logic [SCW-1:0] stab_q, stab_d;
    logic           ack_m_q, ack_m_d;
    logic           ack_s_q, ack_s_d;
    logic [W-1:0]   last_sent_q, last_sent_d;
    logic [1:0]     state_q, state_d;
    logic [TOW-1:0] tmo_q, tmo_d;
    logic [W-1:0]   data_out_q, data_out_d;
    logic           req_q, req_d;
    logic           err_q, err_d;

    // Zero or multiple switches pressed both map to INVALID.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (sw[i]) idx = W'(i);
        end
        onehot = (sw != '0) && ((sw & (sw - N_SW'(1))) == '0);
        code   = onehot ? idx : INVALID;
    end

    assign stable = (stab_q == STAB_MAX);

    always_comb begin
        code_d      = code;
        ack_m_d     = ack;
        ack_s_d     = ack_m_q;
        stab_d      = stab_q;
        last_sent_d = last_sent_q;
        state_d     = state_q;
        tmo_d       = tmo_q;
        data_out_d  = data_out_q;
        req_d       = req_q;
        err_d       = err_q;

        if (code != code_q) begin
            stab_d = '0;
        end else if (!stable) begin
            stab_d = stab_q + SCW'(1);
        end

        case (state_q)
            S_IDLE: begin
                req_d = 1'b0;
                if (!ack_s_q && stable && (code_q != last_sent_q)) begin
                    data_out_d = code_q;
                    req_d      = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT_LOW;
                end else if (tmo_q == TO_LAST) begin
                    // last_sent is left alone so the same code is retried.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TOW'(1);
                end
            end
            S_WAIT_LOW: begin
                req_d = 1'b0;
                if (!ack_s_q) begin
                    last_sent_d = data_out_q;
                    err_d       = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q      <= INVALID;
            stab_q      <= '0;
            ack_m_q     <= 1'b0;
            ack_s_q     <= 1'b0;
            last_sent_q <= INVALID;
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            data_out_q  <= INVALID;
            req_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            code_q      <= code_d;
            stab_q      <= stab_d;
            ack_m_q     <= ack_m_d;
            ack_s_q     <= ack_s_d;
            last_sent_q <= last_sent_d;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            data_out_q  <= data_out_d;
            req_q       <= req_d;
            err_q       <= err_d;
        end
    end

    assign data_out = data_out_q;
    assign req      = req_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lab6_master_hs_tx.sv
// Scoreboarded bench for lab6_master_hs_tx: an 8-switch and a 16-switch
// instance, each answered by a slave model; codes checked on every req rise.
module tb_lab6_master_hs_tx;

    localparam int STABLE_CYC = 4;
    localparam int TIMEOUT    = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic        ack;
    logic [3:0]  data_out;
    logic        req, err;
    logic [15:0] sw16;
    logic        ack16;
    logic [4:0]  data_out16;
    logic        req16, err16;

    always #5 clk = ~clk;

    lab6_master_hs_tx #(.N_SW(8), .STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sw(sw), .ack(ack),
        .data_out(data_out), .req(req), .err(err)
    );

    lab6_master_hs_tx #(.N_SW(16), .STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT)) dut16 (
        .clk(clk), .rst(rst), .sw(sw16), .ack(ack16),
        .data_out(data_out16), .req(req16), .err(err16)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp16_q[$];
    bit   ack_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: one set bit -> its index, anything else -> 1 followed by zeros.
    function automatic logic [7:0] ref_code(input logic [15:0] s, input int w);
        logic [7:0] r;
        r = 8'(1) << (w - 1);
        if ($countones(s) == 1) begin
            for (int i = 0; i < 16; i++) if (s[i]) r = 8'(i);
        end
        return r;
    endfunction

    // Slave models: raise ack two cycles after seeing req, drop it two cycles after req falls.
    int c0 = 0, c1 = 0;
    initial begin
        ack = 1'b0;
        ack16 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack = 1'b0; c0 = 0;
                ack16 = 1'b0; c1 = 0;
            end else begin
                if (!ack) begin
                    if (req && ack_en) begin
                        c0++;
                        if (c0 == 2) begin ack = 1'b1; c0 = 0; end
                    end else c0 = 0;
                end else begin
                    if (!req) begin
                        c0++;
                        if (c0 == 2) begin ack = 1'b0; c0 = 0; end
                    end else c0 = 0;
                end
                if (!ack16) begin
                    if (req16) begin
                        c1++;
                        if (c1 == 2) begin ack16 = 1'b1; c1 = 0; end
                    end else c1 = 0;
                end else begin
                    if (!req16) begin
                        c1++;
                        if (c1 == 2) begin ack16 = 1'b0; c1 = 0; end
                    end else c1 = 0;
                end
            end
        end
    end

    // Monitor: each req rise pops one expected code; data_out must hold while req is high.
    logic       req_prev = 1'b0, req16_prev = 1'b0;
    logic [7:0] held, held16;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req && !req_prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_req: data_out=%0h, expected no request", data_out);
                    end else begin
                        check("sent_code", {28'd0, data_out}, {24'd0, exp_q.pop_front()});
                    end
                    held = {4'd0, data_out};
                end else if (req) begin
                    check("data_hold", {28'd0, data_out}, {24'd0, held});
                end
                if (req16 && !req16_prev) begin
                    if (exp16_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_req16: data_out16=%0h, expected no request", data_out16);
                    end else begin
                        check("sent_code16", {27'd0, data_out16}, {24'd0, exp16_q.pop_front()});
                    end
                    held16 = {3'd0, data_out16};
                end else if (req16) begin
                    check("data_hold16", {27'd0, data_out16}, {24'd0, held16});
                end
            end
            req_prev   = req;
            req16_prev = req16;
        end
    end

    task automatic wait_req_high(input int limit, output int waited);
        waited = 0;
        while (req !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (req !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL req_wait: req=%b after %0d cycles, expected 1", req, waited);
        end
    endtask

    int         waited;
    int         hi_cnt;
    logic [7:0] model_last, prev_code, cl, cg;
    logic [7:0] lsw, gsw;

    initial begin
        rst  = 1'b1;
        sw   = 8'h00;
        sw16 = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_data_out", {28'd0, data_out}, 32'h8);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_data_out16", {27'd0, data_out16}, 32'h10);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic send with latency, plus top code on the 16-switch instance
        exp16_q.push_back(8'h0F);
        sw16 = 16'h8000;
        exp_q.push_back(8'h02);
        sw = 8'h04;
        wait_req_high(50, waited);
        check("latency", waited, STABLE_CYC + 2);
        repeat (30) @(negedge clk);
        check("after_send_data", {28'd0, data_out}, 32'h2);
        check("after_send_req", {31'd0, req}, 32'd0);
        check("after_send_err", {31'd0, err}, 32'd0);
        check("sent16_0f", {27'd0, data_out16}, 32'h0F);

        // Short glitch must not be sent; release the 16-switch bank
        exp16_q.push_back(8'h10);
        sw16 = 16'h0000;
        sw = 8'h0C;
        repeat (2) @(negedge clk);
        sw = 8'h04;
        repeat (30) @(negedge clk);
        check("glitch_data", {28'd0, data_out}, 32'h2);
        check("sent16_invalid", {27'd0, data_out16}, 32'h10);

        // Switch change during a transfer does not disturb data_out
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h05);
        sw = 8'h02;
        wait_req_high(50, waited);
        sw = 8'h20;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("hold_during_hs", {28'd0, data_out}, 32'h1);
        end
        repeat (30) @(negedge clk);
        check("second_code", {28'd0, data_out}, 32'h5);

        // Code then all released -> INVALID is sent
        exp_q.push_back(8'h03);
        sw = 8'h08;
        repeat (30) @(negedge clk);
        exp_q.push_back(8'h08);
        sw = 8'h00;
        repeat (30) @(negedge clk);
        check("invalid_sent", {28'd0, data_out}, 32'h8);

        // Timeout with no ack, then retry succeeds
        ack_en = 1'b0;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h07);
        sw = 8'h80;
        wait_req_high(50, waited);
        hi_cnt = 0;
        while (req === 1'b1 && hi_cnt < 3 * TIMEOUT) begin
            hi_cnt++;
            @(negedge clk);
        end
        check("timeout_len", hi_cnt, TIMEOUT);
        check("timeout_err", {31'd0, err}, 32'd1);
        ack_en = 1'b1;
        repeat (30) @(negedge clk);
        check("err_cleared", {31'd0, err}, 32'd0);
        check("retry_data", {28'd0, data_out}, 32'h7);

        // Randomized rounds: optional short glitch, then a long hold
        model_last = 8'h07;
        prev_code  = 8'h07;
        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 3))
                0: lsw = 8'h00;
                1: begin
                    lsw = 8'($urandom);
                    if ($countones(lsw) < 2) lsw = lsw | 8'h03;
                end
                default: lsw = 8'(1) << $urandom_range(0, 7);
            endcase
            cl = ref_code({8'd0, lsw}, 4);
            if ($urandom_range(0, 1) == 1) begin
                gsw = 8'(1) << $urandom_range(0, 7);
                cg  = ref_code({8'd0, gsw}, 4);
                for (int t = 0; t < 20 && (cg == prev_code || cg == cl); t++) begin
                    gsw = 8'(1) << $urandom_range(0, 7);
                    cg  = ref_code({8'd0, gsw}, 4);
                end
                if (cg != prev_code && cg != cl) begin
                    sw = gsw;
                    repeat ($urandom_range(1, STABLE_CYC)) @(negedge clk);
                end
            end
            if (cl != model_last) begin
                exp_q.push_back(cl);
                model_last = cl;
            end
            sw = lsw;
            repeat (40) @(negedge clk);
            check("rand_data", {28'd0, data_out}, {24'd0, model_last});
            prev_code = cl;
        end

        // Reset in the middle of a handshake
        lsw = (model_last == 8'h06) ? 8'h20 : 8'h40;
        exp_q.push_back(ref_code({8'd0, lsw}, 4));
        sw = lsw;
        wait_req_high(50, waited);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", {31'd0, req}, 32'd0);
        check("midrst_data", {28'd0, data_out}, 32'h8);
        check("midrst_err", {31'd0, err}, 32'd0);
        sw = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("postrst_req", {31'd0, req}, 32'd0);
        check("postrst_data", {28'd0, data_out}, 32'h8);

        check("exp_q_drained", exp_q.size(), 0);
        check("exp16_q_drained", exp16_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
